// File: rtl/sntc_ldpc_bitflip_decoder.sv
// sntc_ldpc_bitflip_decoder: hard-decision bit-flipping LDPC decoder with valid/ready handshake.
// Revision 1.0 - initial release.
`default_nettype none

package sntc_ldpc_pkg;
  localparam int MM = 168;
  localparam int NN = 208;
  // Structured default matrix: rows are successive shifts of a weight-3 seed.
  localparam logic [NN:0] H_ONE = {{NN{1'b0}}, 1'b1};
  localparam logic [NN:0] H_SEED = H_ONE | (H_ONE << 37) | (H_ONE << 101);
  localparam logic [MM*(NN+1)-1:0] H_REP = {MM{H_SEED}};
  localparam logic [MM*NN-1:0] H_MAT = H_REP[MM*NN-1:0];
endpackage

module sntc_ldpc_bitflip_decoder #(
  parameter int MM       = 'h000a8,
  parameter int NN       = 'h000d0,
  parameter int cmax     = 'h00017,
  parameter int rmax     = 'h0000a,
  parameter int MAX_ITER = 16,
  parameter int IW       = (MAX_ITER > 0) ? $clog2(MAX_ITER + 1) : 1,
  parameter logic [MM*NN-1:0] H_MAT = sntc_ldpc_pkg::H_MAT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic [NN-1:0]    y_nr_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [NN-1:0]    y_nr_dec,
  output logic [NN-MM-1:0] msg_dec,
  output logic             dec_ok,
  output logic [IW-1:0]    iter_count,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int UW = $clog2(rmax + 1);

  if (cmax < 1 || rmax < 1) begin : g_param_check
    $error("sntc_ldpc_bitflip_decoder: cmax and rmax must be positive");
  end

  typedef enum logic [2:0] {IDLE, SYND, EVAL, FLIP, DONE} state_t;

  state_t          state;
  logic [NN-1:0]   y_reg;
  logic [NN-1:0]   flip_mask;
  logic [MM-1:0]   syn_reg;
  logic [IW-1:0]   iter;

  logic [MM-1:0]   syn_next;
  logic [NN-1:0]   mask_next;
  logic [UW-1:0]   u [NN];
  logic [UW-1:0]   umax;

  always_comb begin
    syn_next = '0;
    for (int i = 0; i < MM; i++) begin
      syn_next[i] = ^(H_MAT[i*NN +: NN] & y_reg);
    end
  end

  // Unsatisfied-check count per bit, then flip every bit that reaches the maximum.
  always_comb begin
    umax      = '0;
    mask_next = '0;
    for (int j = 0; j < NN; j++) begin
      u[j] = '0;
      for (int i = 0; i < MM; i++) begin
        u[j] = u[j] + UW'(H_MAT[i*NN + j] & syn_reg[i]);
      end
      if (u[j] > umax) umax = u[j];
    end
    for (int j = 0; j < NN; j++) begin
      mask_next[j] = (u[j] == umax);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      state     <= IDLE;
      y_reg     <= '0;
      syn_reg   <= '0;
      flip_mask <= '0;
      iter      <= '0;
      dec_ok    <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            y_reg    <= y_nr_in;
            iter     <= '0;
            in_ready <= 1'b0;
            state    <= SYND;
          end
        end
        SYND: begin
          syn_reg <= syn_next;
          state   <= EVAL;
        end
        EVAL: begin
          if (syn_reg == '0) begin
            dec_ok    <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (iter == IW'(MAX_ITER) || umax == '0) begin
            dec_ok    <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            flip_mask <= mask_next;
            state     <= FLIP;
          end
        end
        FLIP: begin
          y_reg <= y_reg ^ flip_mask;
          iter  <= iter + IW'(1);
          state <= SYND;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign y_nr_dec   = y_reg;
  assign msg_dec    = y_reg[NN-MM-1:0];
  assign iter_count = iter;

endmodule

`default_nettype wire

// File: tb/tb_sntc_ldpc_bitflip_decoder.sv
// Scoreboard bench for the bit-flip decoder on a 3x6 parity-check matrix.
`timescale 1ns/1ps
`default_nettype none

module tb_sntc_ldpc_bitflip_decoder;

  localparam logic [17:0] H_SMALL = 18'b100101_010110_001011;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] a_y_in = '0, a_y_dec, b_y_in = '0, b_y_dec;
  logic [2:0] a_msg, b_msg;
  logic       a_in_valid = 1'b0, a_in_ready, a_ok, a_out_valid, a_out_ready = 1'b1;
  logic       b_in_valid = 1'b0, b_in_ready, b_ok, b_out_valid, b_out_ready = 1'b1;
  logic [2:0] a_iter;
  logic [0:0] b_iter;

  sntc_ldpc_bitflip_decoder #(
    .MM(3), .NN(6), .cmax(3), .rmax(2), .MAX_ITER(4), .H_MAT(H_SMALL)
  ) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .y_nr_in(a_y_in), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .y_nr_dec(a_y_dec), .msg_dec(a_msg), .dec_ok(a_ok),
    .iter_count(a_iter), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  sntc_ldpc_bitflip_decoder #(
    .MM(3), .NN(6), .cmax(3), .rmax(2), .MAX_ITER(0), .H_MAT(H_SMALL)
  ) dut0 (
    .clk(clk), .rstn(rstn), .clr(clr), .y_nr_in(b_y_in), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .y_nr_dec(b_y_dec), .msg_dec(b_msg), .dec_ok(b_ok),
    .iter_count(b_iter), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  typedef struct {
    logic [5:0]  y;
    logic        ok;
    logic [31:0] iter;
    int          lat;
    int          t_acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t cur_a, cur_b;
  bit   hold_a = 1'b0, hold_b = 1'b0;
  int   n_cmp = 0, n_err = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic no_expect(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: output presented with no expected result (cycle %0d)", name, cyc);
  endtask

  // Monitors: compare on the first cycle of each result, then check it holds until taken.
  always @(negedge clk) begin
    if (rstn && !clr && a_out_valid) begin
      if (!hold_a) begin
        if (qa.size() == 0) no_expect("a_unexpected");
        else begin
          cur_a = qa.pop_front();
          chk("a_y_dec", 32'(a_y_dec), 32'(cur_a.y));
          chk("a_msg_dec", 32'(a_msg), 32'(cur_a.y[2:0]));
          chk("a_dec_ok", 32'(a_ok), 32'(cur_a.ok));
          chk("a_iter_count", 32'(a_iter), cur_a.iter);
          chk("a_latency", 32'(cyc - cur_a.t_acc + 1), 32'(cur_a.lat));
        end
        hold_a = 1'b1;
      end else begin
        chk("a_hold_y", 32'(a_y_dec), 32'(cur_a.y));
        chk("a_hold_ok_iter", {28'd0, a_ok, a_iter}, {28'd0, cur_a.ok, cur_a.iter[2:0]});
        chk("a_busy_in_ready", 32'(a_in_ready), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && !clr && b_out_valid && !hold_b) begin
      if (qb.size() == 0) no_expect("b_unexpected");
      else begin
        cur_b = qb.pop_front();
        chk("b_y_dec", 32'(b_y_dec), 32'(cur_b.y));
        chk("b_dec_ok", 32'(b_ok), 32'(cur_b.ok));
        chk("b_iter_count", 32'(b_iter), cur_b.iter);
        chk("b_latency", 32'(cyc - cur_b.t_acc + 1), 32'(cur_b.lat));
      end
      hold_b = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!rstn || clr || (a_out_valid && a_out_ready)) hold_a = 1'b0;
    if (!rstn || clr || (b_out_valid && b_out_ready)) hold_b = 1'b0;
  end

  task automatic send_a(input logic [5:0] y, input logic [5:0] ey, input logic eok,
                        input int eiter, input int elat, input bit push);
    int n = 0;
    while (!a_in_ready && n < 200) begin @(negedge clk); n++; end
    if (!a_in_ready) no_expect("a_in_ready_timeout");
    a_y_in = y;
    a_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    if (push) qa.push_back('{y: ey, ok: eok, iter: 32'(eiter), lat: elat, t_acc: cyc});
  endtask

  task automatic send_b(input logic [5:0] y, input logic [5:0] ey, input logic eok,
                        input int eiter, input int elat);
    int n = 0;
    while (!b_in_ready && n < 200) begin @(negedge clk); n++; end
    if (!b_in_ready) no_expect("b_in_ready_timeout");
    b_y_in = y;
    b_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    qb.push_back('{y: ey, ok: eok, iter: 32'(eiter), lat: elat, t_acc: cyc});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || a_out_valid || b_out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) no_expect(name);
  endtask

  // Abort the single-error word while it sits in FLIP, using clr or rstn.
  task automatic abort_in_flip(input bit use_rst);
    send_a(6'h32, 6'h33, 1'b1, 1, 6, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (use_rst) rstn = 1'b0; else clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    clr  = 1'b0;
    chk(use_rst ? "rst_abort_in_ready" : "clr_abort_in_ready", 32'(a_in_ready), 32'd1);
    chk(use_rst ? "rst_abort_out_valid" : "clr_abort_out_valid", 32'(a_out_valid), 32'd0);
    send_a(6'h33, 6'h33, 1'b1, 0, 3, 1'b1);
    drain("abort_drain_timeout");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 32'(a_in_ready), 32'd1);
    chk("reset_out_valid", 32'(a_out_valid), 32'd0);
    chk("reset_dec_ok", 32'(a_ok), 32'd0);
    chk("reset_iter", 32'(a_iter), 32'd0);
    chk("reset_y_dec", 32'(a_y_dec), 32'd0);
    chk("reset_b_in_ready", 32'(b_in_ready), 32'd1);

    send_a(6'h33, 6'h33, 1'b1, 0, 3, 1'b1);   // clean codeword
    send_a(6'h32, 6'h33, 1'b1, 1, 6, 1'b1);   // j0 wrong
    send_a(6'h37, 6'h33, 1'b1, 1, 6, 1'b1);   // j2 wrong
    send_a(6'h30, 6'h34, 1'b1, 1, 6, 1'b1);   // double error, miscorrects to 6'h34
    send_a(6'h38, 6'h38, 1'b0, 4, 15, 1'b1);  // oscillates until the iteration limit
    send_a(6'h00, 6'h00, 1'b1, 0, 3, 1'b1);
    drain("basic_drain_timeout");

    send_b(6'h32, 6'h32, 1'b0, 0, 3);         // check-only decoder
    send_b(6'h33, 6'h33, 1'b1, 0, 3);
    drain("b_drain_timeout");

    a_out_ready = 1'b0;
    send_a(6'h32, 6'h33, 1'b1, 1, 6, 1'b1);
    a_y_in = 6'h00;
    a_in_valid = 1'b1;
    chk("busy_in_ready_synd", 32'(a_in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int n = 0; n < 50 && !a_out_valid; n++) @(negedge clk);
    repeat (10) @(negedge clk);
    a_out_ready = 1'b1;
    drain("backpressure_drain_timeout");

    abort_in_flip(1'b0);
    abort_in_flip(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
